// File: rtl/seven_seg_pkg.sv
// Shared types and the active-high hex segment table for the seven-segment scanner.
// Segment order is {g,f,e,d,c,b,a}; a set bit means the segment is lit.
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'h00;

  localparam seg_t HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seven_segment_decoder.sv
// Combinational hex nibble to active-high segment pattern (b and d lowercase).
// Zero latency; no flow control.
module seven_segment_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_nib,
  output seg_t       o_seg
);

  assign o_seg = HEX_SEG[i_nib];

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed N-digit seven-segment driver with frame-coherent display updates.
// Outputs are registered one cycle behind the prescaler/index state; no backpressure.
module seven_segment_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYCLES   = 2,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic                    enable,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PR_W  = $clog2(SCAN_DIV);

  localparam logic [PR_W-1:0]  PR_LAST  = PR_W'(SCAN_DIV - 1);
  localparam logic [PR_W-1:0]  PR_BLANK = PR_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  localparam seg_t                  SEG_INV = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_INV  = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_INV  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

  logic [PR_W-1:0]         r_presc;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_pend;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic                    r_pend_vld;
  logic [4*NUM_DIGITS-1:0] r_disp;
  logic [NUM_DIGITS-1:0]   r_disp_dp;

  logic [6:0]            r_seg;
  logic                  r_dp;
  logic [NUM_DIGITS-1:0] r_an;
  logic                  r_frame_done;

  logic                  w_tick;
  logic                  w_wrap;
  logic [3:0]            w_nib;
  logic                  w_dp_hi;
  logic                  w_blank;
  logic                  w_zero_run;
  logic [NUM_DIGITS-1:0] w_lz;
  logic [NUM_DIGITS-1:0] w_an_hi;
  seg_t                  w_dec_seg;
  seg_t                  w_seg_hi;

  assign w_tick = (r_presc == PR_LAST);
  assign w_wrap = w_tick && (r_idx == IDX_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) begin
        r_idx <= w_wrap ? '0 : r_idx + 1'b1;
      end
    end
  end

  // Display only changes at the frame wrap; a load in that cycle wins pending_valid back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend     <= '0;
      r_pend_dp  <= '0;
      r_pend_vld <= 1'b0;
      r_disp     <= '0;
      r_disp_dp  <= '0;
    end else begin
      if (w_wrap && r_pend_vld) begin
        r_disp     <= r_pend;
        r_disp_dp  <= r_pend_dp;
        r_pend_vld <= 1'b0;
      end
      if (load) begin
        r_pend     <= value;
        r_pend_dp  <= dp_in;
        r_pend_vld <= 1'b1;
      end
    end
  end

  // w_lz[i] is set when every nibble from the top digit down to i is zero.
  always_comb begin
    w_lz       = '0;
    w_zero_run = 1'b1;
    w_nib      = 4'h0;
    w_dp_hi    = 1'b0;
    w_blank    = 1'b0;
    w_an_hi    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_zero_run = w_zero_run && (r_disp[4*i +: 4] == 4'h0);
      w_lz[i]    = w_zero_run;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nib      = r_disp[4*i +: 4];
        w_dp_hi    = r_disp_dp[i];
        w_blank    = blank_lz && (i != 0) && w_lz[i];
        w_an_hi[i] = enable && (r_presc >= PR_BLANK);
      end
    end
  end

  seven_segment_decoder u_dec (
    .i_nib (w_nib),
    .o_seg (w_dec_seg)
  );

  assign w_seg_hi = w_blank ? SEG_OFF : w_dec_seg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg        <= SEG_OFF ^ SEG_INV;
      r_dp         <= DP_INV;
      r_an         <= AN_INV;
      r_frame_done <= 1'b0;
    end else begin
      r_seg        <= w_seg_hi ^ SEG_INV;
      r_dp         <= w_dp_hi ^ DP_INV;
      r_an         <= w_an_hi ^ AN_INV;
      r_frame_done <= w_wrap;
    end
  end

  assign seg        = r_seg;
  assign dp         = r_dp;
  assign an         = r_an;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Scoreboard bench for seven_segment_scanner: expected digit images are queued by the
// stimulus thread and popped by a monitor when the matching digit enable goes active.
module tb_seven_segment_scanner;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   value;
  logic [N-1:0]  dp_in;
  logic          load;
  logic          blank_lz;
  logic          enable;
  logic [6:0]    seg;
  logic          dp;
  logic [N-1:0]  an;
  logic          frame_done;

  seven_segment_scanner #(
    .NUM_DIGITS(N), .SCAN_DIV(4), .BLANK_CYCLES(1),
    .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .enable(enable), .seg(seg), .dp(dp), .an(an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S5 = 7'b0010010, SA = 7'b0001000, SF = 7'b0001110,
                         SOFF = 7'b1111111;

  typedef struct {
    int         tag;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  task automatic push(int tag, logic [3:0] a, logic [6:0] s, logic d);
    exp_t e;
    e.tag = tag; e.an = a; e.seg = s; e.dp = d;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && q.size() > 0 && an === q[0].an) begin
      exp_t e;
      e = q.pop_front();
      chk($sformatf("digit_tag%0d an=%b {dp,seg}", e.tag, e.an), {24'd0, dp, seg}, {24'd0, e.dp, e.seg});
    end
  end

  task automatic wait_fd();
    bit ok;
    ok = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (frame_done) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL frame_done_timeout actual=0 required=1");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && q.size() > 0; i++) @(negedge clk);
  endtask

  task automatic do_load(logic [15:0] v, logic [3:0] d);
    value = v; dp_in = d; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Load at a frame start, then return right after the wrap that displays it.
  task automatic load_and_show(logic [15:0] v, logic [3:0] d);
    wait_fd();
    do_load(v, d);
    wait_fd();
  endtask

  initial begin
    int cnt;
    int an_bad;
    bit fd_seen;
    logic [3:0] exp_an;

    rst = 1'b1; value = '0; dp_in = '0; load = 0; blank_lz = 0; enable = 1;
    #12;
    chk("reset_state", {19'd0, an, seg, dp, frame_done}, {19'd0, 4'hF, SOFF, 1'b1, 1'b0});
    @(negedge clk); rst = 1'b0;
    repeat (10) @(negedge clk);

    // Mid-slot asynchronous reset: outputs must change without a clock edge.
    @(posedge clk); #3 rst = 1'b1;
    #1 chk("async_reset_outputs", {19'd0, an, seg, dp, frame_done}, {19'd0, 4'hF, SOFF, 1'b1, 1'b0});
    @(negedge clk); rst = 1'b0;
    cnt = 0;
    while (an === 4'hF && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    chk("first_an_after_reset", {28'd0, an}, {28'd0, 4'b1110});
    chk("first_an_delay", cnt, 2);

    // Hex decode and decimal points.
    load_and_show(16'h12AF, 4'b0010);
    push(10, 4'b1110, SF, 1'b1);
    push(11, 4'b1101, SA, 1'b0);
    push(12, 4'b1011, S2, 1'b1);
    push(13, 4'b0111, S1, 1'b1);
    drain();

    // Leading-zero blanking.
    blank_lz = 1'b1;
    load_and_show(16'h0050, 4'b0000);
    push(20, 4'b1110, S0, 1'b1);
    push(21, 4'b1101, S5, 1'b1);
    push(22, 4'b1011, SOFF, 1'b1);
    push(23, 4'b0111, SOFF, 1'b1);
    drain();
    load_and_show(16'h0000, 4'b0000);
    push(30, 4'b1110, S0, 1'b1);
    push(31, 4'b1101, SOFF, 1'b1);
    push(32, 4'b1011, SOFF, 1'b1);
    push(33, 4'b0111, SOFF, 1'b1);
    drain();
    blank_lz = 1'b0;

    // Two loads during the digit-1 slot: last wins, current frame untouched.
    wait_fd();
    repeat (4) @(negedge clk);
    push(40, 4'b1011, S0, 1'b1);
    push(41, 4'b0111, S0, 1'b1);
    push(42, 4'b1110, S2, 1'b1);
    push(43, 4'b1101, S2, 1'b1);
    push(44, 4'b1011, S2, 1'b1);
    push(45, 4'b0111, S2, 1'b1);
    do_load(16'h1111, 4'b0000);
    do_load(16'h2222, 4'b0000);
    drain();

    // Free run: frame period, pulse width and blank interval at each slot start.
    wait_fd();
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!frame_done && cnt < 40);
    chk("frame_period", cnt, 16);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1) chk("frame_done_width", {31'd0, frame_done}, 32'd0);
      exp_an = ((k - 1) % 4 == 0) ? 4'hF : ~(4'b0001 << ((k - 1) / 4));
      chk($sformatf("slot_an_k%0d", k), {28'd0, an}, {28'd0, exp_an});
    end

    // enable=0 gates only the digit enables.
    enable = 1'b0;
    @(negedge clk);
    an_bad = 0; fd_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (an !== 4'hF) an_bad++;
      if (frame_done) fd_seen = 1;
    end
    chk("enable0_an_cycles_not_1111", an_bad, 0);
    chk("enable0_frame_done_seen", {31'd0, fd_seen}, 32'd1);
    enable = 1'b1;

    drain();
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++; bad++;
      $display("FAIL digit_tag%0d_never_shown actual=none required=an %b", e.tag, e.an);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
